dados_gen: RTL and testbench

//  Dice roller: responder to the game FSM's en_dados/done_dados handshake. One die channel per done bit (2).
//  On enable, each die spins (value 1..6 cycling), decelerates, stops on a final value, then raises done.

---
 rtl/dados_gen_if.sv | 29 ++
 rtl/dados_gen.sv | 161 ++++++++++++++++
 tb/tb_dados_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dados_gen_if.sv
// =============================================================================
// Module  : dados_if
// Brief   : Roll handshake between the game FSM and the dice roller.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface dados_if;
    logic       en_dados_i;
    logic [1:0] done_dados_o;
    logic [2:0] dado0_o;
    logic [2:0] dado1_o;

    modport master (
        output en_dados_i,
        input  done_dados_o,
        input  dado0_o,
        input  dado1_o
    );

    modport slave (
        input  en_dados_i,
        output done_dados_o,
        output dado0_o,
        output dado1_o
    );
endinterface

`default_nettype wire

// File: rtl/dados_gen.sv
// =============================================================================
// Module  : dados_gen
// Brief   : Two independent dice that spin, brake and stop on an LFSR-driven
//           pseudo-random value in response to the game FSM roll request.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dados_gen #(
    parameter int          PERIODO_INI = 2,
    parameter int          GIRO_MIN    = 4,
    parameter int          PASOS_FRENO = 3,
    parameter logic [15:0] SEMILLA0    = 16'hACE1,
    parameter logic [15:0] SEMILLA1    = 16'h1234
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    dados_if.slave    bus
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        GIRA   = 2'd1,
        FRENA  = 2'd2,
        LISTO  = 2'd3
    } estado_t;

    localparam int          c_per_max = PERIODO_INI << PASOS_FRENO;
    localparam int          c_pcw     = (c_per_max > 1) ? $clog2(c_per_max) : 1;
    localparam int          c_prw     = $clog2(c_per_max + 1);
    localparam int          c_gw      = ($clog2(GIRO_MIN + 16) > 5) ? $clog2(GIRO_MIN + 16) : 5;
    localparam int          c_fw      = (PASOS_FRENO > 1) ? $clog2(PASOS_FRENO) : 1;
    localparam logic [15:0] c_taps    = 16'hB400;

    logic [1:0]      w_done;
    logic [1:0][2:0] w_dado;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dado
        localparam logic [15:0] c_sem_raw = (gi == 0) ? SEMILLA0 : SEMILLA1;
        localparam logic [15:0] c_semilla = (c_sem_raw == 16'h0000) ? 16'h0001 : c_sem_raw;

        estado_t          estado_q, estado_d;
        logic [15:0]      lfsr_q, lfsr_d;
        logic [c_gw-1:0]  giro_q, giro_d;
        logic [c_pcw-1:0] per_q, per_d;
        logic [c_prw-1:0] periodo_q, periodo_d;
        logic [c_fw-1:0]  freno_q, freno_d;
        logic [2:0]       valor_q, valor_d;
        logic             done_q, done_d;

        logic             w_tick;
        logic [15:0]      w_lfsr_sig;
        logic [2:0]       w_valor_sig;

        assign w_tick      = (c_prw'(per_q) == periodo_q - c_prw'(1));
        assign w_lfsr_sig  = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_taps) : (lfsr_q >> 1);
        assign w_valor_sig = (valor_q == 3'd6) ? 3'd1 : valor_q + 3'd1;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                estado_q  <= REPOSO;
                lfsr_q    <= c_semilla;
                giro_q    <= '0;
                per_q     <= '0;
                periodo_q <= c_prw'(PERIODO_INI);
                freno_q   <= '0;
                valor_q   <= 3'd1;
                done_q    <= 1'b0;
            end else begin
                estado_q  <= estado_d;
                lfsr_q    <= lfsr_d;
                giro_q    <= giro_d;
                per_q     <= per_d;
                periodo_q <= periodo_d;
                freno_q   <= freno_d;
                valor_q   <= valor_d;
                done_q    <= done_d;
            end
        end

        always_comb begin
            estado_d  = estado_q;
            lfsr_d    = lfsr_q;
            giro_d    = giro_q;
            per_d     = per_q;
            periodo_d = periodo_q;
            freno_d   = freno_q;
            valor_d   = valor_q;
            done_d    = 1'b0;

            case (estado_q)
                REPOSO: begin
                    if (bus.en_dados_i) begin
                        estado_d  = GIRA;
                        giro_d    = c_gw'(GIRO_MIN) + c_gw'(lfsr_q[3:0]);
                        per_d     = '0;
                        periodo_d = c_prw'(PERIODO_INI);
                        freno_d   = '0;
                    end
                end
                GIRA: begin
                    lfsr_d = w_lfsr_sig;
                    // Dropping the request aborts the roll before any pending tick lands.
                    if (!bus.en_dados_i) begin
                        estado_d = REPOSO;
                    end else if (w_tick) begin
                        valor_d = w_valor_sig;
                        per_d   = '0;
                        giro_d  = giro_q - c_gw'(1);
                        if (giro_q <= c_gw'(1)) begin
                            if (PASOS_FRENO == 0) begin
                                estado_d = LISTO;
                            end else begin
                                estado_d  = FRENA;
                                periodo_d = periodo_q << 1;
                            end
                        end
                    end else begin
                        per_d = per_q + c_pcw'(1);
                    end
                end
                FRENA: begin
                    lfsr_d = w_lfsr_sig;
                    if (!bus.en_dados_i) begin
                        estado_d = REPOSO;
                    end else if (w_tick) begin
                        valor_d = w_valor_sig;
                        per_d   = '0;
                        freno_d = freno_q + c_fw'(1);
                        if (freno_q == c_fw'(PASOS_FRENO - 1)) begin
                            estado_d = LISTO;
                        end else begin
                            periodo_d = periodo_q << 1;
                        end
                    end else begin
                        per_d = per_q + c_pcw'(1);
                    end
                end
                LISTO: begin
                    done_d = bus.en_dados_i;
                    if (!bus.en_dados_i) begin
                        estado_d = REPOSO;
                    end
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end

        assign w_done[gi] = done_q;
        assign w_dado[gi] = valor_q;
    end

    assign bus.done_dados_o = w_done;
    assign bus.dado0_o      = w_dado[0];
    assign bus.dado1_o      = w_dado[1];

endmodule

`default_nettype wire

// File: tb/tb_dados_gen.sv
// Bench for dados_gen: two instances (default and fast/no-brake) checked every
// cycle against a roll-level model, plus hand-computed anchor values.
`default_nettype none

module tb_dados_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dados_if busA ();
    dados_if busB ();

    dados_gen dutA (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (busA)
    );

    dados_gen #(
        .PERIODO_INI (1),
        .GIRO_MIN    (4),
        .PASOS_FRENO (0),
        .SEMILLA0    (16'h0000),
        .SEMILLA1    (16'h1234)
    ) dutB (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (busB)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Channels 0,1 = dutA dice; 2,3 = dutB dice.
    int          P    [4] = '{2, 2, 1, 1};
    int          G    [4] = '{4, 4, 4, 4};
    int          F    [4] = '{3, 3, 0, 0};
    logic [15:0] SEED [4] = '{16'hACE1, 16'h1234, 16'h0001, 16'h1234};

    int          phase [4];
    int          e0    [4];
    int          giro  [4];
    int          v0    [4];
    int          val   [4];
    int          dn    [4];
    logic [15:0] lf    [4];
    int          t = 0;
    bit          rand_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int spin_len(input int c);
        return giro[c] * P[c] + P[c] * ((1 << (F[c] + 1)) - 2);
    endfunction

    // Number of value steps completed d cycles after the sampling edge.
    function automatic int ticks(input int c, input int d);
        int n;
        n = d / P[c];
        if (n > giro[c]) n = giro[c];
        for (int j = 1; j <= F[c]; j++)
            if (d >= giro[c] * P[c] + P[c] * ((1 << (j + 1)) - 2)) n++;
        return n;
    endfunction

    function automatic int adv(input int v, input int k);
        return ((v - 1 + k) % 6) + 1;
    endfunction

    task automatic mreset(input int c);
        phase[c] = 0; val[c] = 1; dn[c] = 0; lf[c] = SEED[c];
        giro[c] = 0; e0[c] = 0; v0[c] = 1;
    endtask

    task automatic mstep(input int c, input bit en);
        case (phase[c])
            0: begin
                dn[c] = 0;
                if (en) begin
                    e0[c] = t; giro[c] = G[c] + int'(lf[c][3:0]);
                    v0[c] = val[c]; phase[c] = 1;
                end
            end
            1: begin
                lf[c] = lfsr_step(lf[c]);
                if (!en) phase[c] = 0;
                else begin
                    val[c] = adv(v0[c], ticks(c, t - e0[c]));
                    if (t - e0[c] == spin_len(c)) phase[c] = 2;
                end
            end
            default: begin
                dn[c] = en ? 1 : 0;
                if (!en) phase[c] = 0;
            end
        endcase
    endtask

    // Model update and compare, once per clock.
    initial begin
        for (int c = 0; c < 4; c++) mreset(c);
        forever begin
            @(posedge clk);
            t++;
            for (int c = 0; c < 4; c++) begin
                if (!rst_n) mreset(c);
                else mstep(c, (c < 2) ? busA.en_dados_i : busB.en_dados_i);
            end
            #1;
            for (int c = 0; c < 4; c++) begin
                int ad, av;
                ad = (c < 2) ? int'(busA.done_dados_o[c]) : int'(busB.done_dados_o[c-2]);
                case (c)
                    0: av = int'(busA.dado0_o);
                    1: av = int'(busA.dado1_o);
                    2: av = int'(busB.dado0_o);
                    default: av = int'(busB.dado1_o);
                endcase
                chk($sformatf("model_done ch%0d", c), ad, dn[c]);
                chk($sformatf("model_dado ch%0d", c), av, val[c]);
            end
        end
    end

    task automatic wait_done_a();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk); #2;
            if (busA.done_dados_o == 2'b11) ok = 1;
        end
        if (!ok) chk("timeout_doneA", 0, 1);
    endtask

    initial begin
        int r0, r1, rb, d0, d1, db;
        busA.en_dados_i = 1'b0;
        busB.en_dados_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_doneA", int'(busA.done_dados_o), 0);
        chk("reset_dado0", int'(busA.dado0_o), 1);
        chk("reset_dado1", int'(busA.dado1_o), 1);

        // Default roll with en high straight out of reset.
        @(negedge clk);
        busA.en_dados_i = 1'b1; busB.en_dados_i = 1'b1; rst_n = 1'b1;
        r0 = -1; r1 = -1; rb = -1; d0 = 0; d1 = 0; db = 0;
        for (int k = 0; k <= 50; k++) begin
            @(posedge clk); #2;
            if (k == 0) begin
                chk("model_giro0", giro[0], 5);
                chk("model_giro1", giro[1], 8);
                chk("model_giroB0", giro[2], 5);
            end
            if (busA.done_dados_o[0] && r0 < 0) begin r0 = k; d0 = int'(busA.dado0_o); end
            if (busA.done_dados_o[1] && r1 < 0) begin r1 = k; d1 = int'(busA.dado1_o); end
            if (busB.done_dados_o[0] && rb < 0) begin rb = k; db = int'(busB.dado0_o); end
            if (k == 44) chk("doneA_at44", int'(busA.done_dados_o), 1);
        end
        chk("done0_edge", r0, 39);
        chk("dado0_final", d0, 3);
        chk("done1_edge", r1, 45);
        chk("dado1_final", d1, 6);
        chk("doneB0_edge", rb, 6);
        chk("dadoB0_final", db, 6);

        // Hold, then release.
        repeat (20) @(posedge clk);
        #2;
        chk("hold_doneA", int'(busA.done_dados_o), 3);
        @(negedge clk);
        busA.en_dados_i = 1'b0; busB.en_dados_i = 1'b0;
        @(posedge clk); #2;
        chk("drop_doneA", int'(busA.done_dados_o), 0);
        chk("drop_dado0", int'(busA.dado0_o), 3);
        chk("drop_dado1", int'(busA.dado1_o), 6);
        chk("drop_doneB", int'(busB.done_dados_o), 0);

        // Abort: en sampled low on edge 10 of the roll.
        @(negedge clk);
        busA.en_dados_i = 1'b1;
        repeat (10) @(negedge clk);
        busA.en_dados_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_doneA", int'(busA.done_dados_o), 0);
        chk("abort_dado0", int'(busA.dado0_o), 1);
        chk("abort_dado1", int'(busA.dado1_o), 4);

        // Full roll on the advanced LFSR.
        @(negedge clk);
        busA.en_dados_i = 1'b1;
        wait_done_a();
        @(negedge clk);
        busA.en_dados_i = 1'b0;

        // Asynchronous reset in the middle of a roll.
        @(negedge clk);
        busA.en_dados_i = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_doneA", int'(busA.done_dados_o), 0);
        chk("async_dado0", int'(busA.dado0_o), 1);
        chk("async_dado1", int'(busA.dado1_o), 1);
        @(negedge clk);
        busA.en_dados_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised back-to-back rolls; dutB gets random request levels.
        rand_b = 1;
        for (int r = 0; r < 100; r++) begin
            @(negedge clk);
            busA.en_dados_i = 1'b1;
            if ($urandom % 8 == 0) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end else begin
                wait_done_a();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
            end
            busA.en_dados_i = 1'b0;
        end
        rand_b = 0;
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_b) busB.en_dados_i = ($urandom % 8 != 0);
        end
    end

endmodule

`default_nettype wire
